cordic_arbiter: RTL and testbench

- Shares one iterative cosine CORDIC engine among N_REQ requesters, e.g. custom-instruction ports and a DMA-fed batch path.
- Picks one pending request, latches its angle and issues a single start pulse to the engine.
- Clock-enables the engine while busy, waits for done or timeout, then latches the result.
- Returns the result to the winning requester with a valid/ready handshake; sits between the CPU-side request ports and the engine.

---
 rtl/cordic_pkg.sv | 18 +
 rtl/cordic_arbiter_rr_picker.sv | 37 +++
 rtl/cordic_arbiter.sv | 129 ++++++++++++
 tb/tb_cordic_arbiter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared types and constants for the CORDIC engine arbiter.
package cordic_pkg;

   localparam int WIDTH_DEF = 23;
   localparam int FRACS_DEF = 21;
   localparam int INTS_DEF  = 1;

   // Q1.21 representation of 1.0 on the result bus
   localparam logic [WIDTH_DEF-2:0] ONE = 22'h200000;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      BUSY,
      RESPOND
   } arb_state_t;

endpackage

// File: rtl/cordic_arbiter_rr_picker.sv
// Rotating-mask priority encoder: first set request at or above ptr, else lowest overall.
module rr_picker #(
   parameter int N = 2,
   parameter int W = 1
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic [N-1:0] grant,
   output logic [W-1:0] idx
);

   logic [N-1:0] mask;
   logic [N-1:0] masked;

   function automatic logic [W-1:0] lowest(input logic [N-1:0] v);
      logic [W-1:0] r;
      r = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (v[i]) r = W'(i);
      end
      return r;
   endfunction

   always_comb begin
      mask = '0;
      for (int i = 0; i < N; i++) begin
         mask[i] = (i >= int'(ptr));
      end
   end

   always_comb begin
      masked = req & mask;
      idx    = (|masked) ? lowest(masked) : lowest(req);
      grant  = (|req) ? (N'(1) << idx) : '0;
   end

endmodule

// File: rtl/cordic_arbiter.sv
// Shares one iterative cosine CORDIC engine among N_REQ requesters.
// Define CORDIC_ARB_RR_EN for round-robin arbitration; otherwise lowest index wins.
module cordic_arbiter
   import cordic_pkg::*;
#(
   parameter int N_REQ   = 2,
   parameter int WIDTH   = WIDTH_DEF,
   parameter int TIMEOUT = 32
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [N_REQ-1:0]          req_valid,
   input  logic [N_REQ*WIDTH-1:0]    req_theta,
   output logic [N_REQ-1:0]          req_ready,
   output logic [N_REQ-1:0]          rsp_valid,
   input  logic [N_REQ-1:0]          rsp_ready,
   output logic [WIDTH-2:0]          rsp_result,
   output logic                      rsp_error,
   output logic                      core_start,
   output logic signed [WIDTH-1:0]   core_theta,
   output logic                      core_clk_en,
   input  logic                      core_done,
   input  logic [WIDTH-2:0]          core_result
);

   localparam int ID_W  = $clog2(N_REQ);
   localparam int TMR_W = $clog2(TIMEOUT + 1);

   arb_state_t              state;
   logic [ID_W-1:0]         id_q;
   logic [ID_W-1:0]         ptr;
   logic [ID_W-1:0]         pick_idx;
   logic [N_REQ-1:0]        pick_grant;
   logic signed [WIDTH-1:0] theta_q;
   logic [TMR_W-1:0]        timer;
   logic [WIDTH-2:0]        result_q;
   logic                    error_q;
   logic                    start_q;
   logic                    clk_en_q;
   logic [N_REQ-1:0]        rsp_valid_q;

`ifdef CORDIC_ARB_RR_EN
   logic [ID_W-1:0] rr_ptr;
   assign ptr = rr_ptr;

   function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
      return (int'(id) == N_REQ - 1) ? '0 : id + 1'b1;
   endfunction
`else
   assign ptr = '0;
`endif

   rr_picker #(
      .N (N_REQ),
      .W (ID_W)
   ) u_picker (
      .req   (req_valid),
      .ptr   (ptr),
      .grant (pick_grant),
      .idx   (pick_idx)
   );

   // Grant is combinational so the requester sees acceptance in the same cycle
   assign req_ready   = (reset && state == IDLE) ? pick_grant : '0;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_result  = result_q;
   assign rsp_error   = error_q;
   assign core_start  = start_q;
   assign core_theta  = theta_q;
   assign core_clk_en = clk_en_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= IDLE;
         id_q        <= '0;
         theta_q     <= '0;
         timer       <= '0;
         result_q    <= '0;
         error_q     <= 1'b0;
         start_q     <= 1'b0;
         clk_en_q    <= 1'b0;
         rsp_valid_q <= '0;
`ifdef CORDIC_ARB_RR_EN
         rr_ptr      <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (|req_valid) begin
                  id_q     <= pick_idx;
                  theta_q  <= req_theta[int'(pick_idx)*WIDTH +: WIDTH];
                  start_q  <= 1'b1;
                  clk_en_q <= 1'b1;
                  state    <= ISSUE;
               end
            end
            ISSUE: begin
               start_q <= 1'b0;
               timer   <= '0;
               state   <= BUSY;
            end
            BUSY: begin
               timer <= timer + 1'b1;
               // A done arriving on the last allowed cycle still counts as success
               if (core_done || timer == TMR_W'(TIMEOUT - 1)) begin
                  result_q    <= core_done ? core_result : '0;
                  error_q     <= !core_done;
                  clk_en_q    <= 1'b0;
                  rsp_valid_q <= N_REQ'(1) << id_q;
                  state       <= RESPOND;
               end
            end
            RESPOND: begin
               if (rsp_ready[id_q]) begin
                  rsp_valid_q <= '0;
                  result_q    <= '0;
                  error_q     <= 1'b0;
                  state       <= IDLE;
`ifdef CORDIC_ARB_RR_EN
                  rr_ptr      <= next_id(id_q);
`endif
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cordic_arbiter.sv
// Randomized bench for cordic_arbiter with a transaction-level reference model and stub engine.
module tb_cordic_arbiter;
   import cordic_pkg::*;

   localparam int N  = 2;
   localparam int W  = 23;
   localparam int TO = 32;
   localparam int RW = W - 1;

   logic                  clk = 1'b0;
   logic                  reset;
   logic [N-1:0]          req_valid;
   logic [N*W-1:0]        req_theta;
   logic [N-1:0]          req_ready;
   logic [N-1:0]          rsp_valid;
   logic [N-1:0]          rsp_ready;
   logic [RW-1:0]         rsp_result;
   logic                  rsp_error;
   logic                  core_start;
   logic signed [W-1:0]   core_theta;
   logic                  core_clk_en;
   logic                  core_done;
   logic [RW-1:0]         core_result;

   int n_chk = 0;
   int n_err = 0;
   int rr_model = 0;

   always #5 clk = ~clk;

   cordic_arbiter #(
      .N_REQ   (N),
      .WIDTH   (W),
      .TIMEOUT (TO)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_theta   (req_theta),
      .req_ready   (req_ready),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_result  (rsp_result),
      .rsp_error   (rsp_error),
      .core_start  (core_start),
      .core_theta  (core_theta),
      .core_clk_en (core_clk_en),
      .core_done   (core_done),
      .core_result (core_result)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Winner chosen from the arbitration rules directly
   function automatic int pick(input logic [N-1:0] m, input int p);
`ifdef CORDIC_ARB_RR_EN
      for (int i = 0; i < N; i++) begin
         if (m[(p + i) % N]) return (p + i) % N;
      end
`else
      for (int i = 0; i < N; i++) begin
         if (m[i]) return i;
      end
`endif
      return -1;
   endfunction

   function automatic logic [63:0] all_outs();
      return {req_ready, rsp_valid, rsp_result, rsp_error, core_start,
              core_theta, core_clk_en};
   endfunction

   // d: engine cycles from ISSUE to done (0 = never); bp: cycles of rsp_ready withheld
   task automatic run_txn(input logic [N-1:0] mask, input int d, input logic [RW-1:0] res,
                          input int bp);
      int                  win;
      int                  eff;
      bit                  ok;
      logic [N-1:0]        oh;
      logic [N*W-1:0]      thetas;
      logic signed [W-1:0] th;
      logic [RW-1:0]       exp_res;

      for (int k = 0; k < N; k++) thetas[k*W +: W] = W'($urandom);
      win     = pick(mask, rr_model);
      oh      = N'(1) << win;
      th      = thetas[win*W +: W];
      ok      = (d != 0) && (d <= TO);
      eff     = ok ? d : TO;
      exp_res = ok ? res : '0;

      req_valid   = mask;
      req_theta   = thetas;
      core_done   = 1'(($urandom));
      core_result = res;
      #1;
      chk("grant", req_ready, oh);

      step();
      req_theta = {$urandom, $urandom};
      req_valid = N'($urandom);
      #1;
      chk("issue_start", core_start, 1'b1);
      chk("issue_clk_en", core_clk_en, 1'b1);
      chk("issue_theta", core_theta, th);
      chk("issue_no_grant", req_ready, '0);

      for (int c = 2; c < 2 + eff; c++) begin
         step();
         core_done = (c == 1 + d);
         req_valid = N'($urandom);
         #1;
         chk("busy_no_rsp", rsp_valid, '0);
         if (c == 2) begin
            chk("busy_start", core_start, 1'b0);
            chk("busy_clk_en", core_clk_en, 1'b1);
         end
      end

      step();
      core_done = 1'b0;
      req_valid = N'($urandom);
      rsp_ready = (bp == 0) ? oh : (N'($urandom) & ~oh);
      #1;
      chk("rsp_valid", rsp_valid, oh);
      chk("rsp_result", rsp_result, exp_res);
      chk("rsp_error", rsp_error, !ok);
      chk("rsp_clk_en", core_clk_en, 1'b0);

      for (int i = 0; i < bp; i++) begin
         step();
         core_done = 1'($urandom);
         req_valid = N'($urandom);
         rsp_ready = (i == bp - 1) ? oh : (N'($urandom) & ~oh);
         #1;
         chk("hold_valid", rsp_valid, oh);
         chk("hold_result", {rsp_error, rsp_result}, {!ok, exp_res});
         chk("hold_clk_en", core_clk_en, 1'b0);
         chk("hold_no_grant", req_ready, '0);
      end

      step();
      rsp_ready = '0;
      core_done = 1'b0;
      req_valid = '0;
      #1;
      chk("rsp_released", rsp_valid, '0);
      rr_model = (win + 1) % N;
   endtask

   task automatic reset_mid_busy();
      logic [N-1:0] seen;
      req_valid = N'($urandom_range(1, (1 << N) - 1));
      req_theta = {$urandom, $urandom};
      core_done = 1'b0;
      #1;
      step();
      req_valid = '0;
      repeat (3) step();
      reset = 1'b0;
      step();
      reset = 1'b1;
      #1;
      chk("midrst_outs", all_outs(), '0);
      seen = '0;
      for (int i = 0; i < 40; i++) begin
         step();
         core_done = 1'($urandom);
         #1;
         seen = seen | rsp_valid;
      end
      core_done = 1'b0;
      chk("midrst_no_rsp", seen, '0);
      rr_model = 0;
   endtask

   function automatic int rand_delay();
      int s;
      s = $urandom_range(0, 9);
      if (s <= 5) return $urandom_range(1, 8);
      if (s == 6) return TO - 1;
      if (s == 7) return TO;
      if (s == 8) return TO + 1;
      return 0;
   endfunction

   initial begin
      #3000000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset       = 1'b0;
      req_valid   = '0;
      req_theta   = '0;
      rsp_ready   = '0;
      core_done   = 1'b0;
      core_result = '0;
      step();
      step();
      req_valid = '1;
      #1;
      chk("reset_outs", all_outs(), '0);
      req_valid = '0;
      reset = 1'b1;
      step();

      // Stub engine finishing 4 cycles after start with 1.0
      run_txn(2'b01, 4, ONE, 0);
      // Contention: both requesters keep asking
      for (int i = 0; i < 4; i++) run_txn(2'b11, 3, RW'($urandom), 0);
      // Timeout, then normal service
      run_txn(2'b10, 0, RW'($urandom), 0);
      run_txn(2'b01, 5, RW'($urandom), 0);
      // Backpressure
      run_txn(2'b11, 2, RW'($urandom), 10);
      // Done coincides with last timer cycle
      run_txn(2'b01, TO, RW'($urandom), 1);
      reset_mid_busy();
      run_txn(2'b11, 4, ONE, 0);

      for (int t = 0; t < 40; t++) begin
         run_txn(N'($urandom_range(1, (1 << N) - 1)), rand_delay(), RW'($urandom),
                 $urandom_range(0, 4));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
